paddle_mask_tracker: RTL
========================

Name: paddle_mask_tracker

Overview:
- Consumes the binary merged edge/color mask stream, one pixel per valid cycle in raster order, as emitted by the paddle-localization merge stage.
- Per frame it counts mask pixels and tracks the bounding box and the coordinate sums.
- At frame end it snapshots the results and computes the integer centroid with a serial divider.
- Publishes paddle position to downstream game/overlay logic with a one-cycle result strobe.

Parameters:
- WIDTH, 640, active pixels per row
- HEIGHT, 480, active rows per frame
- COORD_W, 13, width of row/col coordinates
- CNT_W, 19, width of mask pixel count
- ACC_W, 32, width of coordinate-sum accumulators and divider operands
- MIN_PIXELS, 16, minimum mask count for a detection

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  pixel qualifier; a pixel is accepted only when high
- in_pixel  in  1  merged mask bit (1 = paddle edge)
- frame_sync  in  1  one-cycle pulse; restarts the frame at col=0,row=0 and discards partial accumulation
- result_valid  out  1  one-cycle strobe; new results are present
- detected  out  1  mask count >= MIN_PIXELS
- x_min, x_max, y_min, y_max  out  COORD_W each  bounding box
- x_cen, y_cen  out  COORD_W each  floor(sum/count) centroid
- pix_count  out  CNT_W  mask pixels in frame
- overrun  out  1  sticky; a frame end occurred while the divider was busy

Behaviour:
- Reset (reset_n=0 at a clk edge): all outputs 0, col/row=0, accumulators cleared, FSM=IDLE. Reset mid-divide aborts the divide; no result_valid follows.

Raster counters:
- col increments on each accepted pixel.
- At col=WIDTH-1, col wraps to 0 and row increments. At row=HEIGHT-1, row wraps to 0.
- in_valid=0 freezes the counters.
- frame_sync has priority over in_valid in the same cycle. The pixel in that cycle is ignored and the counters go to 0.

Accumulation, per accepted pixel with in_pixel=1:
- count+1
- sum_x+=col, sum_y+=row
- min/max update; the bbox registers initialise to min=all-ones, max=0 at frame start.

Frame end (accepted pixel at col=WIDTH-1, row=HEIGHT-1, cycle T):
- That pixel is included.
- At T+1 the snapshot registers load and the accumulators clear, so the next frame accumulates from T+1.

FSM states: IDLE, DIV_X, DIV_Y, PUBLISH.
- IDLE: on snapshot, go to DIV_X if snap_count >= MIN_PIXELS (start divider on sum_x/count), else go to PUBLISH.
- DIV_X: on div_done, latch x_cen, start sum_y/count, go to DIV_Y.
- DIV_Y: on div_done, latch y_cen, go to PUBLISH.
- PUBLISH: drive outputs from the snapshot, assert result_valid for 1 cycle, go to IDLE.
- When not detected: detected=0; x_min/x_max/y_min/y_max/x_cen/y_cen=0; pix_count=snap_count.

Divider and latency:
- Divider latency DIV_LAT = ACC_W+1 cycles from start to done.
- Detected: result_valid at T+2+2*DIV_LAT.
- Not detected: result_valid at T+2.

Outputs and overrun:
- Outputs hold their values between strobes.
- A frame end while the FSM is not IDLE drops the new snapshot and sets overrun. Only reset clears overrun.
- The accumulators still clear, so the following frame is unaffected.
- Quotients fit COORD_W by construction (centroid lies inside the bbox). Truncation to COORD_W is safe.

Optional Feature:
PADDLE_MASK_ROI_EN
- Defined: adds inputs roi_x_lo, roi_x_hi, roi_y_lo, roi_y_hi (COORD_W each).
  - ROI bounds are sampled at frame start and held for the frame.
  - A mask pixel outside the inclusive ROI still advances the counters but is not accumulated.
- Undefined: no ROI ports; the whole frame is accumulated.

Decomposition:
- Package paddle_track_pkg:
  - state enum (IDLE, DIV_X, DIV_Y, PUBLISH)
  - result struct (bbox, centroid, count, detected)
  - localparam DIV_LAT function of ACC_W
- Sub-module serial_divider: unsigned restoring divider, ACC_W bits, one quotient bit per cycle.
  - Ports: start/dividend/divisor in; done/quotient out.
  - Divisor 0 yields quotient 0, but is never started with it.

Test Plan (WIDTH=8, HEIGHT=6, MIN_PIXELS=1, ACC_W=16):
- Single mask pixel at (col3,row2), in_valid continuous -> result_valid at T+36; detected=1, bbox 3/3/2/2, cen (3,2), pix_count=1.
- Mask cols 2-4 × rows 1-3, in_valid toggling 1/0 -> pix_count=9, bbox 2/4/1/3, cen (3,2); gaps do not shift coordinates.
- All-zero frame -> result_valid at T+2; detected=0, all coords 0, pix_count=0.
- frame_sync at col5,row3 after mask pixels -> those pixels are discarded; the next full frame with pixel (1,1) yields cen (1,1), count 1.
- Back-to-back frames with ACC_W=32 (DIV_LAT 33, 2*33 > 48 pixels/frame) -> second frame end sets overrun=1; first frame's result is still published once.
- reset_n low during DIV_Y -> no result_valid; all outputs 0; next frame reports correctly.

Source files
------------

// File: rtl/paddle_track_pkg.sv
// Shared types for the paddle mask tracker.
//   track_state_e  : result-sequencing FSM states
//   track_result_t : published result (bbox, centroid, count, detected)
//   div_lat()      : serial divider latency, start to done, for an acc_w-bit divider
package paddle_track_pkg;

  // Result fields are sized for the default coordinate and count widths.
  localparam int unsigned CoordW = 13;
  localparam int unsigned CntW   = 19;

  typedef enum logic [1:0] {
    StIdle,
    StDivX,
    StDivY,
    StPublish
  } track_state_e;

  typedef struct packed {
    logic              detected;
    logic [CoordW-1:0] x_min;
    logic [CoordW-1:0] x_max;
    logic [CoordW-1:0] y_min;
    logic [CoordW-1:0] y_max;
    logic [CoordW-1:0] x_cen;
    logic [CoordW-1:0] y_cen;
    logic [CntW-1:0]   pix_count;
  } track_result_t;

  // One cycle to load operands plus one cycle per quotient bit.
  function automatic int unsigned div_lat(int unsigned acc_w);
    return acc_w + 1;
  endfunction

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
//   clk, reset_n : clock, synchronous active-low reset (aborts any divide in flight)
//   start_i      : load dividend_i / divisor_i and begin; restarts if already busy
//   done_o       : one-cycle pulse div_lat(ACC_W) cycles after start_i
//   quotient_o   : low QUOT_W bits of floor(dividend/divisor); 0 when divisor is 0
module serial_divider
  import paddle_track_pkg::*;
#(
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned QUOT_W = 13
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic [ACC_W-1:0]  dividend_i,
  input  logic [ACC_W-1:0]  divisor_i,
  output logic              done_o,
  output logic [QUOT_W-1:0] quotient_o
);

  localparam int unsigned DIV_LAT = div_lat(ACC_W);
  localparam int unsigned StepW   = $clog2(DIV_LAT);

  logic             busy_q, done_q, div_zero_q;
  logic [StepW-1:0] step_q;
  logic [ACC_W-1:0] rem_q, quot_q, divisor_q, rem_d;
  logic [ACC_W:0]   shifted;
  logic             fits;

  // Shift the next dividend bit into the partial remainder and try a subtraction.
  always_comb begin
    shifted = {rem_q, quot_q[ACC_W-1]};
    fits    = shifted >= {1'b0, divisor_q};
    rem_d   = fits ? ACC_W'(shifted - {1'b0, divisor_q}) : shifted[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      step_q     <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      divisor_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        busy_q     <= 1'b1;
        step_q     <= StepW'(DIV_LAT - 1);
        rem_q      <= '0;
        quot_q     <= dividend_i;
        divisor_q  <= divisor_i;
        div_zero_q <= (divisor_i == '0);
      end else if (busy_q) begin
        rem_q  <= rem_d;
        quot_q <= {quot_q[ACC_W-2:0], fits};
        step_q <= step_q - StepW'(1);
        if (step_q == StepW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o     = done_q;
  assign quotient_o = div_zero_q ? '0 : quot_q[QUOT_W-1:0];

endmodule

// File: rtl/paddle_mask_tracker.sv
// Paddle mask tracker: per-frame count, bounding box and centroid of a binary mask stream.
//   clk, reset_n       : clock, synchronous active-low reset
//   in_valid, in_pixel : raster-order mask pixel and its qualifier
//   frame_sync         : restarts the frame at (0,0), discarding partial accumulation
//   result_valid       : one-cycle strobe when new results are on the outputs
//   detected, x_/y_min/max, x_/y_cen, pix_count : held result of the last published frame
//   overrun            : sticky, a frame ended while the previous result was still in progress
// Optional: define PADDLE_MASK_ROI_EN to add roi_x_lo/roi_x_hi/roi_y_lo/roi_y_hi; mask pixels
// outside the inclusive ROI (bounds captured at frame start) are not accumulated.
module paddle_mask_tracker
  import paddle_track_pkg::*;
#(
  parameter int unsigned WIDTH      = 640,
  parameter int unsigned HEIGHT     = 480,
  parameter int unsigned COORD_W    = 13,
  parameter int unsigned CNT_W      = 19,
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned MIN_PIXELS = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic               in_pixel,
  input  logic               frame_sync,
`ifdef PADDLE_MASK_ROI_EN
  input  logic [COORD_W-1:0] roi_x_lo,
  input  logic [COORD_W-1:0] roi_x_hi,
  input  logic [COORD_W-1:0] roi_y_lo,
  input  logic [COORD_W-1:0] roi_y_hi,
`endif
  output logic               result_valid,
  output logic               detected,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] y_max,
  output logic [COORD_W-1:0] x_cen,
  output logic [COORD_W-1:0] y_cen,
  output logic [CNT_W-1:0]   pix_count,
  output logic               overrun
);

  logic accept, last_col, last_row, frame_end, in_roi, hit;
  logic [COORD_W-1:0] col_q, col_d, row_q, row_d;

  assign accept    = in_valid && !frame_sync;
  assign last_col  = (col_q == COORD_W'(WIDTH - 1));
  assign last_row  = (row_q == COORD_W'(HEIGHT - 1));
  assign frame_end = accept && last_col && last_row;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (frame_sync) begin
      col_d = '0;
      row_d = '0;
    end else if (in_valid) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + COORD_W'(1);
      end else begin
        col_d = col_q + COORD_W'(1);
      end
    end
  end

`ifdef PADDLE_MASK_ROI_EN
  logic               at_origin;
  logic [COORD_W-1:0] roi_x_lo_q, roi_x_hi_q, roi_y_lo_q, roi_y_hi_q;
  logic [COORD_W-1:0] rxl, rxh, ryl, ryh;

  // Bounds follow the inputs until the frame's first pixel is accepted, then hold.
  assign at_origin = (col_q == '0) && (row_q == '0);
  assign rxl = at_origin ? roi_x_lo : roi_x_lo_q;
  assign rxh = at_origin ? roi_x_hi : roi_x_hi_q;
  assign ryl = at_origin ? roi_y_lo : roi_y_lo_q;
  assign ryh = at_origin ? roi_y_hi : roi_y_hi_q;
  assign in_roi = (col_q >= rxl) && (col_q <= rxh) && (row_q >= ryl) && (row_q <= ryh);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      roi_x_lo_q <= '0;
      roi_x_hi_q <= '0;
      roi_y_lo_q <= '0;
      roi_y_hi_q <= '0;
    end else if (accept && at_origin) begin
      roi_x_lo_q <= roi_x_lo;
      roi_x_hi_q <= roi_x_hi;
      roi_y_lo_q <= roi_y_lo;
      roi_y_hi_q <= roi_y_hi;
    end
  end
`else
  assign in_roi = 1'b1;
`endif

  assign hit = accept && in_pixel && in_roi;

  // Accumulators, including the pixel of the current cycle.
  logic [CNT_W-1:0]   count_q, count_nx, snap_count_q;
  logic [ACC_W-1:0]   sum_x_q, sum_x_nx, sum_y_q, sum_y_nx, snap_sum_x_q, snap_sum_y_q;
  logic [COORD_W-1:0] x_min_q, x_min_nx, x_max_q, x_max_nx;
  logic [COORD_W-1:0] y_min_q, y_min_nx, y_max_q, y_max_nx;
  logic [COORD_W-1:0] snap_x_min_q, snap_x_max_q, snap_y_min_q, snap_y_max_q;

  always_comb begin
    count_nx = count_q;
    sum_x_nx = sum_x_q;
    sum_y_nx = sum_y_q;
    x_min_nx = x_min_q;
    x_max_nx = x_max_q;
    y_min_nx = y_min_q;
    y_max_nx = y_max_q;
    if (hit) begin
      count_nx = count_q + CNT_W'(1);
      sum_x_nx = sum_x_q + ACC_W'(col_q);
      sum_y_nx = sum_y_q + ACC_W'(row_q);
      x_min_nx = (col_q < x_min_q) ? col_q : x_min_q;
      x_max_nx = (col_q > x_max_q) ? col_q : x_max_q;
      y_min_nx = (row_q < y_min_q) ? row_q : y_min_q;
      y_max_nx = (row_q > y_max_q) ? row_q : y_max_q;
    end
  end

  track_state_e  state_q, state_d;
  track_result_t res_q, res_d;
  logic          snap_pend_q, snap_load, busy, snap_det, overrun_q, pub_load;
  logic          div_start, div_done;
  logic [ACC_W-1:0]   div_dividend, div_divisor;
  logic [COORD_W-1:0] div_quot, x_cen_q, x_cen_d;

  // A snapshot is taken only when no earlier result is still being worked on.
  assign busy      = (state_q != StIdle) || snap_pend_q;
  assign snap_load = frame_end && !busy;
  assign snap_det  = (snap_count_q >= CNT_W'(MIN_PIXELS));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      col_q        <= '0;
      row_q        <= '0;
      count_q      <= '0;
      sum_x_q      <= '0;
      sum_y_q      <= '0;
      x_min_q      <= '1;
      x_max_q      <= '0;
      y_min_q      <= '1;
      y_max_q      <= '0;
      snap_count_q <= '0;
      snap_sum_x_q <= '0;
      snap_sum_y_q <= '0;
      snap_x_min_q <= '0;
      snap_x_max_q <= '0;
      snap_y_min_q <= '0;
      snap_y_max_q <= '0;
      snap_pend_q  <= 1'b0;
      overrun_q    <= 1'b0;
      state_q      <= StIdle;
      x_cen_q      <= '0;
      res_q        <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (frame_sync || frame_end) begin
        count_q <= '0;
        sum_x_q <= '0;
        sum_y_q <= '0;
        x_min_q <= '1;
        x_max_q <= '0;
        y_min_q <= '1;
        y_max_q <= '0;
      end else begin
        count_q <= count_nx;
        sum_x_q <= sum_x_nx;
        sum_y_q <= sum_y_nx;
        x_min_q <= x_min_nx;
        x_max_q <= x_max_nx;
        y_min_q <= y_min_nx;
        y_max_q <= y_max_nx;
      end
      if (snap_load) begin
        snap_count_q <= count_nx;
        snap_sum_x_q <= sum_x_nx;
        snap_sum_y_q <= sum_y_nx;
        snap_x_min_q <= x_min_nx;
        snap_x_max_q <= x_max_nx;
        snap_y_min_q <= y_min_nx;
        snap_y_max_q <= y_max_nx;
      end
      snap_pend_q <= snap_load;
      if (frame_end && busy) overrun_q <= 1'b1;
      state_q <= state_d;
      x_cen_q <= x_cen_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    div_start    = 1'b0;
    div_dividend = snap_sum_x_q;
    pub_load     = 1'b0;
    x_cen_d      = x_cen_q;
    unique case (state_q)
      StIdle: begin
        if (snap_pend_q) begin
          if (snap_det) begin
            div_start = 1'b1;
            state_d   = StDivX;
          end else begin
            pub_load = 1'b1;
            state_d  = StPublish;
          end
        end
      end
      StDivX: begin
        if (div_done) begin
          x_cen_d      = div_quot;
          div_start    = 1'b1;
          div_dividend = snap_sum_y_q;
          state_d      = StDivY;
        end
      end
      StDivY: begin
        if (div_done) begin
          pub_load = 1'b1;
          state_d  = StPublish;
        end
      end
      StPublish: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Result registers load on entry to StPublish; y centroid comes straight off the divider.
  always_comb begin
    res_d = res_q;
    if (pub_load) begin
      res_d           = '0;
      res_d.pix_count = CntW'(snap_count_q);
      if (snap_det) begin
        res_d.detected = 1'b1;
        res_d.x_min    = CoordW'(snap_x_min_q);
        res_d.x_max    = CoordW'(snap_x_max_q);
        res_d.y_min    = CoordW'(snap_y_min_q);
        res_d.y_max    = CoordW'(snap_y_max_q);
        res_d.x_cen    = CoordW'(x_cen_q);
        res_d.y_cen    = CoordW'(div_quot);
      end
    end
  end

  assign div_divisor = ACC_W'(snap_count_q);

  serial_divider #(
    .ACC_W (ACC_W),
    .QUOT_W(COORD_W)
  ) u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_i   (div_start),
    .dividend_i(div_dividend),
    .divisor_i (div_divisor),
    .done_o    (div_done),
    .quotient_o(div_quot)
  );

  assign result_valid = (state_q == StPublish);
  assign detected     = res_q.detected;
  assign x_min        = COORD_W'(res_q.x_min);
  assign x_max        = COORD_W'(res_q.x_max);
  assign y_min        = COORD_W'(res_q.y_min);
  assign y_max        = COORD_W'(res_q.y_max);
  assign x_cen        = COORD_W'(res_q.x_cen);
  assign y_cen        = COORD_W'(res_q.y_cen);
  assign pix_count    = CNT_W'(res_q.pix_count);
  assign overrun      = overrun_q;

endmodule
